pop_param_controller: RTL

POP_PARAM_CONTROLLER -- requirements
Module: pop_param_controller

---
 rtl/pop_cfg_pkg.sv | 39 +++
 rtl/press_repeat_fsm.sv | 122 ++++++++++++
 rtl/pop_param_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pop_cfg_pkg.sv
// rtl/pop_cfg_pkg.sv - shared state/command encodings and timing constants for the POP parameter controller
package pop_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEBOUNCE  = 2'd1,
        ST_HOLD_WAIT = 2'd2,
        ST_REPEAT    = 2'd3
    } fsm_state_t;

    // Order matches button priority: lowest code wins when several are pressed.
    typedef enum logic [1:0] {
        CMD_PIE_PLUS  = 2'd0,
        CMD_PIE_MINUS = 2'd1,
        CMD_FP_PLUS   = 2'd2,
        CMD_FP_MINUS  = 2'd3
    } cmd_t;

    localparam int PIE_DEFAULT_C  = 25;
    localparam int PIE_MIN_C      = 1;
    localparam int PIE_MAX_C      = 1000;
    localparam int FP_DEFAULT_C   = 250;
    localparam int FP_MIN_C       = 1;
    localparam int FP_MAX_C       = 10000;
    localparam int STEP_C         = 1;
    localparam int DEB_TICKS_C    = 3;
    localparam int HOLD_TICKS_C   = 5000;
    localparam int REPEAT_TICKS_C = 1000;

    // Tick counter width large enough for the longest of the three intervals.
    function automatic int cnt_bits(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/press_repeat_fsm.sv
// rtl/press_repeat_fsm.sv - button press debounce, hold delay and auto-repeat step generator
module press_repeat_fsm
    import pop_cfg_pkg::*;
#(
    parameter int DEB_TICKS    = DEB_TICKS_C,
    parameter int HOLD_TICKS   = HOLD_TICKS_C,
    parameter int REPEAT_TICKS = REPEAT_TICKS_C
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic abort,
    input  logic pie_plus,
    input  logic pie_minus,
    input  logic fp_plus,
    input  logic fp_minus,
    output logic step,
    output cmd_t cmd
);

    localparam int CNT_W = cnt_bits(DEB_TICKS, HOLD_TICKS, REPEAT_TICKS);

    fsm_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    cmd_t             cmd_next;
    logic             held;
    logic             any_press;

    // Level of the button that owns the current press.
    always_comb begin
        held = 1'b0;
        case (cmd)
            CMD_PIE_PLUS:  held = pie_plus;
            CMD_PIE_MINUS: held = pie_minus;
            CMD_FP_PLUS:   held = fp_plus;
            CMD_FP_MINUS:  held = fp_minus;
            default:       held = 1'b0;
        endcase
    end

    // State, tick counter and latched command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cmd   <= CMD_PIE_PLUS;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cmd   <= cmd_next;
        end
    end

    // Next-state and step strobe; everything advances only on tick cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_next   = cmd;
        step       = 1'b0;
        cnt_inc    = cnt + CNT_W'(1);
        any_press  = pie_plus | pie_minus | fp_plus | fp_minus;
        if (tick) begin
            if (abort) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_press) begin
                            state_next = ST_DEBOUNCE;
                            cnt_next   = '0;
                            if (pie_plus)       cmd_next = CMD_PIE_PLUS;
                            else if (pie_minus) cmd_next = CMD_PIE_MINUS;
                            else if (fp_plus)   cmd_next = CMD_FP_PLUS;
                            else                cmd_next = CMD_FP_MINUS;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!held) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_inc == CNT_W'(DEB_TICKS)) begin
                            step       = 1'b1;
                            state_next = ST_HOLD_WAIT;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    ST_HOLD_WAIT: begin
                        if (!held) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_inc == CNT_W'(HOLD_TICKS)) begin
                            step       = 1'b1;
                            state_next = ST_REPEAT;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    ST_REPEAT: begin
                        if (!held) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_inc == CNT_W'(REPEAT_TICKS)) begin
                            step     = 1'b1;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pop_param_controller.sv
// rtl/pop_param_controller.sv - staged/active pi-2 and free-precession timing words with button adjust
module pop_param_controller
    import pop_cfg_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int PIE_DEFAULT  = PIE_DEFAULT_C,
    parameter int PIE_MIN      = PIE_MIN_C,
    parameter int PIE_MAX      = PIE_MAX_C,
    parameter int FP_DEFAULT   = FP_DEFAULT_C,
    parameter int FP_MIN       = FP_MIN_C,
    parameter int FP_MAX       = FP_MAX_C,
    parameter int STEP         = STEP_C,
    parameter int DEB_TICKS    = DEB_TICKS_C,
    parameter int HOLD_TICKS   = HOLD_TICKS_C,
    parameter int REPEAT_TICKS = REPEAT_TICKS_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load_defaults,
    input  logic             pie_plus,
    input  logic             pie_minus,
    input  logic             fp_plus,
    input  logic             fp_minus,
    input  logic             cycle_start,
    output logic [WIDTH-1:0] pie_width,
    output logic [WIDTH-1:0] fp_width,
    output logic             cfg_update,
    output logic             pending
);

    // One extra bit so increments and decrements can be range-checked without wrap.
    localparam logic [WIDTH:0]   PIE_MIN_X  = (WIDTH+1)'(PIE_MIN);
    localparam logic [WIDTH:0]   PIE_MAX_X  = (WIDTH+1)'(PIE_MAX);
    localparam logic [WIDTH:0]   FP_MIN_X   = (WIDTH+1)'(FP_MIN);
    localparam logic [WIDTH:0]   FP_MAX_X   = (WIDTH+1)'(FP_MAX);
    localparam logic [WIDTH:0]   STEP_X     = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] PIE_DEF_W  = WIDTH'(PIE_DEFAULT);
    localparam logic [WIDTH-1:0] FP_DEF_W   = WIDTH'(FP_DEFAULT);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic             step;
    cmd_t             cmd;
    logic             defaults_now;
    logic [WIDTH-1:0] pie_stage, fp_stage;
    logic [WIDTH-1:0] pie_stage_next, fp_stage_next;
    logic [WIDTH-1:0] pie_act_next, fp_act_next;
    logic [WIDTH:0]   pie_up, pie_dn, fp_up, fp_dn;
    logic [WIDTH-1:0] pie_inc_sat, pie_dec_sat, fp_inc_sat, fp_dec_sat;

    // Reset asserts immediately and releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign defaults_now = tick & load_defaults;

    press_repeat_fsm #(
        .DEB_TICKS    (DEB_TICKS),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_press (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .tick      (tick),
        .abort     (load_defaults),
        .pie_plus  (pie_plus),
        .pie_minus (pie_minus),
        .fp_plus   (fp_plus),
        .fp_minus  (fp_minus),
        .step      (step),
        .cmd       (cmd)
    );

    // Saturating step candidates for both staged words.
    always_comb begin
        pie_up      = {1'b0, pie_stage} + STEP_X;
        pie_dn      = {1'b0, pie_stage} - STEP_X;
        fp_up       = {1'b0, fp_stage} + STEP_X;
        fp_dn       = {1'b0, fp_stage} - STEP_X;
        pie_inc_sat = (pie_up > PIE_MAX_X) ? PIE_MAX_X[WIDTH-1:0] : pie_up[WIDTH-1:0];
        pie_dec_sat = (pie_dn[WIDTH] || (pie_dn < PIE_MIN_X)) ? PIE_MIN_X[WIDTH-1:0] : pie_dn[WIDTH-1:0];
        fp_inc_sat  = (fp_up > FP_MAX_X) ? FP_MAX_X[WIDTH-1:0] : fp_up[WIDTH-1:0];
        fp_dec_sat  = (fp_dn[WIDTH] || (fp_dn < FP_MIN_X)) ? FP_MIN_X[WIDTH-1:0] : fp_dn[WIDTH-1:0];
    end

    // Staged word update (defaults beat steps) and active load at the cycle boundary.
    always_comb begin
        pie_stage_next = pie_stage;
        fp_stage_next  = fp_stage;
        pie_act_next   = pie_width;
        fp_act_next    = fp_width;
        if (defaults_now) begin
            pie_stage_next = PIE_DEF_W;
            fp_stage_next  = FP_DEF_W;
        end else if (step) begin
            case (cmd)
                CMD_PIE_PLUS:  pie_stage_next = pie_inc_sat;
                CMD_PIE_MINUS: pie_stage_next = pie_dec_sat;
                CMD_FP_PLUS:   fp_stage_next  = fp_inc_sat;
                CMD_FP_MINUS:  fp_stage_next  = fp_dec_sat;
                default:       pie_stage_next = pie_stage;
            endcase
        end
        if (cycle_start && pending) begin
            pie_act_next = pie_stage;
            fp_act_next  = fp_stage;
        end
    end

    // Word registers; pending tracks any staged/active difference after the edge.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pie_stage  <= PIE_DEF_W;
            fp_stage   <= FP_DEF_W;
            pie_width  <= PIE_DEF_W;
            fp_width   <= FP_DEF_W;
            pending    <= 1'b0;
            cfg_update <= 1'b0;
        end else begin
            pie_stage  <= pie_stage_next;
            fp_stage   <= fp_stage_next;
            pie_width  <= pie_act_next;
            fp_width   <= fp_act_next;
            pending    <= (pie_stage_next != pie_act_next) || (fp_stage_next != fp_act_next);
            cfg_update <= cycle_start & pending;
        end
    end

endmodule
